btn_counter: RTL and testbench
==============================

BTN_COUNTER -- requirements
Module: btn_counter

Interface
REQ-001 Parameter DB_CYCLES, default 500000, debounce interval in clk cycles; legal range 2 to 2^20-1.
REQ-002 Parameter MAX_VAL, default 255, upper count limit; legal range 1 to 255.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port clr  input  1  reset; asynchronous, active-high.
REQ-005 Port btn_up  input  1  raw, unsynchronised, bouncing increment push-button; high = pressed.
REQ-006 Port btn_down  input  1  raw decrement push-button; same properties as btn_up.
REQ-007 Port load  input  1  synchronous load strobe; already synchronous to clk.
REQ-008 Port din  input  8  load value; sampled when load=1.
REQ-009 Port wrap_en  input  1  1 = wrap at the limits; 0 = saturate; synchronous, sampled every cycle.
REQ-010 Port x  output  8  current count, registered; feeds the BCD/7-segment display stage.
REQ-011 Port changed  output  1  one-cycle pulse, high in the cycle in which x first shows a new value.

Function
REQ-012 Each button shall pass through its own two-flop synchroniser before any other logic uses it.
REQ-013 Each button shall have its own debounce FSM with states IDLE, PRESS_WAIT, HELD, REL_WAIT, and its own counter, at least 20 bits wide.
REQ-014 IDLE transitions: sync=1 -> PRESS_WAIT with counter=0; otherwise stay in IDLE.
REQ-015 PRESS_WAIT transitions:
- sync=0 -> IDLE.
- sync=1 and counter=DB_CYCLES-1 -> HELD, and the registered press pulse goes high for exactly one cycle.
- otherwise counter+1.
REQ-016 HELD transitions: sync=0 -> REL_WAIT with counter=0; otherwise stay in HELD, with no further pulses (no auto-repeat).
REQ-017 REL_WAIT transitions:
- sync=1 -> HELD.
- sync=0 and counter=DB_CYCLES-1 -> IDLE.
- otherwise counter+1.
REQ-018 Latency: btn sampled high at edge 0 and held stable -> press pulse high after edge DB_CYCLES+2 -> x updated and changed=1 after edge DB_CYCLES+3.
REQ-019 Count update priority, evaluated each cycle:
- (1) load=1: x <= min(din, MAX_VAL).
- (2) up and down pulses in the same cycle: no change.
- (3) up pulse: increment.
- (4) down pulse: decrement.
- (5) otherwise hold.
REQ-020 Increment at x=MAX_VAL: wrap_en=1 -> 0; wrap_en=0 -> x stays at MAX_VAL.
REQ-021 Decrement at x=0: wrap_en=1 -> MAX_VAL; wrap_en=0 -> x stays at 0.
REQ-022 A press pulse coinciding with load shall be discarded; it shall not be applied in a later cycle.
REQ-023 changed shall be registered alongside x and be 1 only if the new x differs from the old x; a saturated press, or a load of an equal value, gives changed=0.
REQ-024 Bounce shorter than DB_CYCLES consecutive stable samples shall produce no pulse, in either the press or the release direction.
REQ-025 A new press shall be recognised only after the FSM has returned to IDLE.
REQ-026 x shall always satisfy 0 <= x <= MAX_VAL.

Reset
REQ-027 While clr=1, the following shall hold immediately, independent of clk:
- x=0 and changed=0.
- both FSMs in IDLE, both debounce counters=0, press pulses=0.
- synchronisers=0.
REQ-028 clr asserted mid-debounce or mid-press shall abort it; after release, a still-held button shall be treated as a new press from IDLE, with full DB_CYCLES latency.
REQ-029 On clr release, the first state change shall occur no earlier than the first rising clk edge after clr falls.

Verification (DB_CYCLES=4, MAX_VAL=255 unless stated)
REQ-030 btn_up high and stable from edge 0 -> x goes 0->1 with changed=1 exactly after edge 7; changed=0 after edge 8; holding the button 100 more cycles keeps x=1.
REQ-031 btn_up toggled every 3 cycles for 30 cycles, then low -> x stays 0 and changed never pulses.
REQ-032 Saturation and wrap, MAX_VAL=9:
- load din=9, wrap_en=0, one up press -> x=9, changed=0.
- wrap_en=1, one up press -> x=0, changed=1.
- one down press -> x=9.
REQ-033 Simultaneous and load cases:
- btn_up and btn_down rise on the same edge -> x unchanged.
- load din=200 in the cycle an up pulse fires -> x=200, not 201.
- load din=250 with MAX_VAL=100 -> x=100.
REQ-034 clr pulsed while x=37 and btn_down is held mid-PRESS_WAIT -> x=0 at once; after release, the still-held btn_down saturates and x stays 0 (wrap_en=0).

Source files
------------

// File: rtl/btn_counter.sv
// Debounced up/down push-button counter with synchronous load and wrap/saturate limits.
// Latency: a stable press is seen by x and changed DB_CYCLES+3 clk edges after the button is first sampled high.
// Flow control: none. Every pulse is applied or discarded in the cycle it appears, and nothing is queued.
//
// Ports:
//   clk       system clock, rising edge
//   clr       asynchronous active-high reset
//   btn_up    raw bouncing increment button (high = pressed)
//   btn_down  raw bouncing decrement button (high = pressed)
//   load      synchronous load strobe; x <= min(din, MAX_VAL)
//   din       load value
//   wrap_en   1 = wrap at 0/MAX_VAL, 0 = saturate
//   x         registered count, always within 0..MAX_VAL
//   changed   one-cycle pulse in the first cycle x shows a new value

// Per-button synchroniser plus debounce FSM; emits one registered pulse per accepted press.
module btn_counter_db #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic press
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        btn_s;
  state_t      state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic        press_nxt;

  // Two-flop synchroniser; nothing downstream looks at the raw pin.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], btn};
  end

  assign btn_s = sync_q[1];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  // Any sample that disagrees with the level being qualified drops the FSM
  // back to the settled state, so only an unbroken run of DB_CYCLES+1 samples
  // flips the debounced level. HELD never re-fires: no auto-repeat.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = REL_WAIT;
          cnt_nxt   = '0;
        end
      end
      REL_WAIT: begin
        if (btn_s) begin
          state_nxt = HELD;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

module btn_counter #(
  parameter int DB_CYCLES = 500000,
  parameter int MAX_VAL   = 255
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       wrap_en,
  output logic [7:0] x,
  output logic       changed
);

  localparam logic [7:0] MAX8 = 8'(MAX_VAL);

  logic       up_p, down_p;
  logic [7:0] x_nxt;

  btn_counter_db #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk   (clk),
    .clr   (clr),
    .btn   (btn_up),
    .press (up_p)
  );

  btn_counter_db #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk   (clk),
    .clr   (clr),
    .btn   (btn_down),
    .press (down_p)
  );

  // Load wins outright, so a pulse landing on a load cycle is lost rather
  // than deferred. Simultaneous up and down cancel.
  always_comb begin
    x_nxt = x;
    if (load) begin
      x_nxt = (din > MAX8) ? MAX8 : din;
    end else if (up_p && down_p) begin
      x_nxt = x;
    end else if (up_p) begin
      if (x == MAX8) x_nxt = wrap_en ? 8'd0 : MAX8;
      else           x_nxt = x + 8'd1;
    end else if (down_p) begin
      if (x == 8'd0) x_nxt = wrap_en ? MAX8 : 8'd0;
      else           x_nxt = x - 8'd1;
    end
  end

  // changed is registered alongside x, so it marks the first cycle of a new value.
  // A saturated press or an equal-value load leaves it low.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x       <= 8'd0;
      changed <= 1'b0;
    end else begin
      x       <= x_nxt;
      changed <= (x_nxt != x);
    end
  end

endmodule

// File: tb/tb_btn_counter.sv
// Bench for btn_counter: three instances with MAX_VAL 255, 9 and 100 share one stimulus stream.
// A run-length debounce model predicts x/changed every cycle into a queue that a monitor drains.
// Directed scenarios add fixed-value checks on top of the randomized phase.
module tb_btn_counter;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, load = 1'b0, wrap_en = 1'b0;
  logic [7:0] din = 8'd0;
  logic [7:0] x0, x1, x2;
  logic       ch0, ch1, ch2;

  btn_counter #(.DB_CYCLES(DB), .MAX_VAL(255)) u0 (
    .clk(clk), .clr(clr), .btn_up(btn_up), .btn_down(btn_down), .load(load),
    .din(din), .wrap_en(wrap_en), .x(x0), .changed(ch0));
  btn_counter #(.DB_CYCLES(DB), .MAX_VAL(9)) u1 (
    .clk(clk), .clr(clr), .btn_up(btn_up), .btn_down(btn_down), .load(load),
    .din(din), .wrap_en(wrap_en), .x(x1), .changed(ch1));
  btn_counter #(.DB_CYCLES(DB), .MAX_VAL(100)) u2 (
    .clk(clk), .clr(clr), .btn_up(btn_up), .btn_down(btn_down), .load(load),
    .din(din), .wrap_en(wrap_en), .x(x2), .changed(ch2));

  always #5 clk = ~clk;

  // Model state: raw-pin delay line, debounced level, run length of samples
  // disagreeing with that level, pending press pulse, count.
  typedef struct {
    bit h1u, h2u, h1d, h2d;
    bit lu, ld_l, pu, pd, ch;
    int ru, rd, x;
  } mst_t;

  typedef struct packed {
    logic [7:0] x0; logic c0;
    logic [7:0] x1; logic c1;
    logic [7:0] x2; logic c2;
  } exp_t;

  mst_t m[3];
  int   maxv[3] = '{255, 9, 100};
  exp_t sbq[$];

  int n_tests = 0, n_fail = 0, cyc_n = 0;
  bit r_clr = 1'b1, r_up = 1'b0, r_dn = 1'b0, r_ld = 1'b0, r_wr = 1'b0;
  logic [7:0] r_din = 8'd0;
  bit prev_clr = 1'b1;
  bit [2:0] seen_ch = 3'b000;

  // A level flips once DB+1 consecutive synchronised samples disagree with it.
  function automatic void filt(input bit s, input bit lvl_i, input int run_i,
                               output bit lvl_o, output int run_o, output bit pulse);
    lvl_o = lvl_i;
    pulse = 1'b0;
    run_o = 0;
    if (s != lvl_i) begin
      run_o = run_i + 1;
      if (run_o == DB + 1) begin
        lvl_o = s;
        run_o = 0;
        pulse = s;
      end
    end
  endfunction

  function automatic mst_t step(input mst_t s, input bit c, input bit up, input bit dn,
                                input bit ld, input int dv, input bit wr, input int mx);
    mst_t n;
    bit   pu_new, pd_new;
    int   nx;
    n = s;
    if (c) begin
      n = '{default: 0};
      return n;
    end
    filt(s.h2u, s.lu,   s.ru, n.lu,   n.ru, pu_new);
    filt(s.h2d, s.ld_l, s.rd, n.ld_l, n.rd, pd_new);
    nx = s.x;
    if (ld)                nx = (dv > mx) ? mx : dv;
    else if (s.pu && s.pd) nx = s.x;
    else if (s.pu)         nx = (s.x == mx) ? (wr ? 0 : mx) : s.x + 1;
    else if (s.pd)         nx = (s.x == 0) ? (wr ? mx : 0) : s.x - 1;
    n.ch  = (nx != s.x);
    n.x   = nx;
    n.h2u = s.h1u; n.h1u = up;
    n.h2d = s.h1d; n.h1d = dn;
    n.pu  = pu_new;
    n.pd  = pd_new;
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc_n);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, advance the model,
  // queue the prediction, return 1 time unit after the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    clr = r_clr; btn_up = r_up; btn_down = r_dn; load = r_ld; din = r_din; wrap_en = r_wr;
    for (int k = 0; k < 3; k++)
      m[k] = step(m[k], r_clr, r_up, r_dn, r_ld, int'(r_din), r_wr, maxv[k]);
    e.x0 = 8'(m[0].x); e.c0 = m[0].ch;
    e.x1 = 8'(m[1].x); e.c1 = m[1].ch;
    e.x2 = 8'(m[2].x); e.c2 = m[2].ch;
    sbq.push_back(e);
    if (r_clr && !prev_clr) begin
      // clr rises mid-cycle: outputs must clear without waiting for a clock edge.
      #1;
      chk("clr_async_x0", int'(x0), 0);
      chk("clr_async_x1", int'(x1), 0);
      chk("clr_async_x2", int'(x2), 0);
      chk("clr_async_changed", int'({ch2, ch1, ch0}), 0);
    end
    prev_clr = r_clr;
    @(posedge clk);
    #1;
    cyc_n++;
    seen_ch |= {ch2, ch1, ch0};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press_up();
    r_up = 1'b1; run(10);
    r_up = 1'b0; run(10);
  endtask

  task automatic press_down();
    r_dn = 1'b1; run(10);
    r_dn = 1'b0; run(10);
  endtask

  task automatic sb_cmp(input int k, input logic [7:0] ax, input logic ac,
                        input logic [7:0] ex, input logic ec);
    n_tests++;
    if ({ax, ac} !== {ex, ec}) begin
      n_fail++;
      $display("FAIL sb_u%0d cycle %0d: x=%0d changed=%0b, expected x=%0d changed=%0b",
               k, cyc_n, ax, ac, ex, ec);
    end
  endtask

  // Monitor: x/changed are registered outputs presented every cycle.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      sb_cmp(0, x0, ch0, e.x0, e.c0);
      sb_cmp(1, x1, ch1, e.x1, e.c1);
      sb_cmp(2, x2, ch2, e.x2, e.c2);
    end
  end

  initial begin
    int up_left, dn_left;
    for (int k = 0; k < 3; k++) m[k] = '{default: 0};

    // Reset state
    run(3);
    chk("reset_x0", int'(x0), 0);
    chk("reset_x1", int'(x1), 0);
    chk("reset_x2", int'(x2), 0);
    chk("reset_changed", int'({ch2, ch1, ch0}), 0);

    // Stable press from edge 0: count moves after edge 7, no auto-repeat
    r_clr = 1'b0;
    cyc();
    r_up = 1'b1;
    for (int i = 0; i <= 108; i++) begin
      cyc();
      if (i == 6) chk("lat_e6_x", int'(x0), 0);
      if (i == 7) begin
        chk("lat_e7_x", int'(x0), 1);
        chk("lat_e7_changed", int'(ch0), 1);
      end
      if (i == 8) chk("lat_e8_changed", int'(ch0), 0);
    end
    chk("held_no_repeat", int'(x0), 1);
    r_up = 1'b0;
    run(10);

    // Bounce: 3-cycle runs never qualify
    r_clr = 1'b1; run(2);
    r_clr = 1'b0; run(2);
    seen_ch = 3'b000;
    for (int i = 0; i < 30; i++) begin
      r_up = ((i / 3) % 2) == 0;
      cyc();
    end
    r_up = 1'b0;
    run(12);
    chk("bounce_x", int'(x0), 0);
    chk("bounce_changed", int'(seen_ch), 0);

    // Saturate then wrap on the MAX_VAL=9 instance
    r_wr = 1'b0; r_din = 8'd9; r_ld = 1'b1; cyc(); r_ld = 1'b0;
    seen_ch = 3'b000;
    press_up();
    chk("sat_up_x", int'(x1), 9);
    chk("sat_up_changed", int'(seen_ch[1]), 0);
    r_wr = 1'b1; seen_ch = 3'b000;
    press_up();
    chk("wrap_up_x", int'(x1), 0);
    chk("wrap_up_changed", int'(seen_ch[1]), 1);
    press_down();
    chk("wrap_down_x", int'(x1), 9);
    chk("wrap_down_x0", int'(x0), 10);

    // Up and down together cancel
    r_up = 1'b1; r_dn = 1'b1; run(10);
    r_up = 1'b0; r_dn = 1'b0; run(10);
    chk("both_x0", int'(x0), 10);
    chk("both_x1", int'(x1), 9);
    chk("both_x2", int'(x2), 10);

    // Load in the same cycle the up pulse is applied: pulse discarded
    r_up = 1'b1; r_din = 8'd200;
    for (int i = 0; i < 10; i++) begin
      r_ld = (i == 7);
      cyc();
    end
    r_ld = 1'b0; r_up = 1'b0;
    run(10);
    chk("load_vs_pulse_x0", int'(x0), 200);
    chk("load_vs_pulse_x2", int'(x2), 100);

    // Load clamps to MAX_VAL; equal-value load gives no changed pulse
    r_din = 8'd250; r_ld = 1'b1; cyc();
    chk("load250_changed", int'(ch0), 1);
    cyc();
    chk("load_equal_changed", int'(ch0), 0);
    r_ld = 1'b0; cyc();
    chk("load_clamp_x2", int'(x2), 100);
    chk("load250_x0", int'(x0), 250);

    // clr during PRESS_WAIT; held button afterwards saturates at 0
    r_wr = 1'b0; r_din = 8'd37; r_ld = 1'b1; cyc(); r_ld = 1'b0; cyc();
    chk("pre_clr_x0", int'(x0), 37);
    r_dn = 1'b1; run(4);
    r_clr = 1'b1; run(2);
    r_clr = 1'b0; seen_ch = 3'b000;
    run(15);
    chk("post_clr_sat_x0", int'(x0), 0);
    chk("post_clr_sat_changed", int'(seen_ch), 0);
    r_dn = 1'b0;
    run(10);

    // Randomized phase: mixed press lengths, bounces, loads, mode flips, resets
    up_left = 1; dn_left = 1;
    for (int i = 0; i < 2500; i++) begin
      if (--up_left == 0) begin r_up = ~r_up; up_left = $urandom_range(1, 12); end
      if (--dn_left == 0) begin r_dn = ~r_dn; dn_left = $urandom_range(1, 12); end
      r_ld  = ($urandom_range(0, 39) == 0);
      r_din = 8'($urandom);
      if ($urandom_range(0, 63) == 0) r_wr = 1'($urandom);
      r_clr = ($urandom_range(0, 399) == 0);
      cyc();
    end
    r_clr = 1'b0; r_ld = 1'b0; r_up = 1'b0; r_dn = 1'b0;
    run(3);
    #3;
    chk("sb_drain", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
